// File: rtl/pc_stack_controller.sv
// Return-address stack sequencer for CALL/RET: pushes the PC on call, pops it
// onto the PC load bus on return, and reports busy/done/error status.
module pc_stack_controller #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [DATA_W-1:0] pc_current,
  input  logic              clear_err,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] pc_load_value,
  output logic              pc_load_en,
  output logic [PTR_W:0]    sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned SP_W = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_P = SP_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, ACK, ERR} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0]      sp_q;
  logic [DATA_W-1:0]   pc_load_value_q;
  logic                busy_q, done_q, err_q, load_q;
  logic                empty_q, full_q, ovf_q, unf_q;

  logic                push_c;
  logic [PTR_W:0]      sp_inc, sp_dec;
  logic [PTR_W-1:0]    wr_idx, rd_idx;

  assign push_c = (state_q == IDLE) && call_req && !full_q;
  assign sp_inc = sp_q + SP_W'(1);
  assign sp_dec = sp_q - SP_W'(1);
  // Top of stack sits one below sp; at sp==DEPTH the low bits wrap to the last entry.
  assign wr_idx = sp_q[PTR_W-1:0];
  assign rd_idx = sp_q[PTR_W-1:0] - PTR_W'(1);

  // Storage is not reset; only the pointer defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_idx] <= pc_current;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      sp_q            <= '0;
      pc_load_value_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      load_q          <= 1'b0;
      empty_q         <= 1'b1;
      full_q          <= 1'b0;
      ovf_q           <= 1'b0;
      unf_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      // Clear first so a same-cycle error set below takes precedence.
      if (clear_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (call_req) begin
            busy_q <= 1'b1;
            done_q <= 1'b1;
            if (full_q) begin
              ovf_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              sp_q    <= sp_inc;
              empty_q <= 1'b0;
              full_q  <= (sp_inc == DEPTH_P);
              state_q <= ACK;
            end
          end else if (ret_req) begin
            busy_q <= 1'b1;
            if (empty_q) begin
              unf_q   <= 1'b1;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              sp_q            <= sp_dec;
              full_q          <= 1'b0;
              empty_q         <= (sp_dec == '0);
              pc_load_value_q <= mem_q[rd_idx];
              load_q          <= 1'b1;
              state_q         <= LOAD;
            end
          end
        end
        LOAD: begin
          done_q  <= 1'b1;
          state_q <= ACK;
        end
        ACK, ERR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign pc_load_en    = load_q;
  assign pc_load_value = pc_load_value_q;
  assign sp            = sp_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_pc_stack_controller.sv
// Scoreboard bench for pc_stack_controller: a LIFO model predicts pops and
// completion status, a negedge monitor compares them as the DUT emits them.
module tb_pc_stack_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       call_req = 1'b0, ret_req = 1'b0, clear_err = 1'b0;
  logic [7:0] pc_current = 8'h00;
  logic       busy, done, err, pc_load_en, empty, full, overflow, underflow;
  logic [7:0] pc_load_value;
  logic [4:0] sp;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic [7:0] stk [16];
  int         sp_m = 0;
  logic       ovf_m = 1'b0, unf_m = 1'b0;
  logic [7:0] sb_pc [$];
  logic [1:0] sb_op [$];  // bit1: error expected, bit0: return op
  logic       prev_en = 1'b0;

  pc_stack_controller dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .pc_current(pc_current), .clear_err(clear_err), .busy(busy), .done(done),
    .err(err), .pc_load_value(pc_load_value), .pc_load_en(pc_load_en),
    .sp(sp), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: consumes scoreboard entries as strobes appear.
  always @(negedge clk) begin
    if (pc_load_en) begin
      if (sb_pc.size() == 0) chk("unexpected_load", 32'(1), 32'(0));
      else chk("pc_load_value", 32'(pc_load_value), 32'(sb_pc.pop_front()));
    end
    if (done) begin
      if (sb_op.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
      else begin
        logic [1:0] op;
        op = sb_op.pop_front();
        chk("done_err", 32'(err), 32'(op[1]));
        chk("load_before_done", 32'(prev_en), 32'(op[0] & ~op[1]));
      end
    end
    prev_en = pc_load_en;
  end

  task automatic check_status(input string tag);
    chk({tag, "_sp"}, 32'(sp), 32'(sp_m));
    chk({tag, "_empty"}, 32'(empty), 32'(sp_m == 0));
    chk({tag, "_full"}, 32'(full), 32'(sp_m == 16));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
    chk({tag, "_unf"}, 32'(underflow), 32'(unf_m));
  endtask

  task automatic do_op(input logic c, input logic r, input logic [7:0] v,
                       input logic clr, input string tag);
    @(negedge clk);
    call_req = c; ret_req = r; pc_current = v; clear_err = clr;
    if (clr) begin ovf_m = 1'b0; unf_m = 1'b0; end
    if (c) begin
      if (sp_m == 16) begin ovf_m = 1'b1; sb_op.push_back(2'b10); end
      else begin stk[sp_m] = v; sp_m++; sb_op.push_back(2'b00); end
    end else if (r) begin
      if (sp_m == 0) begin unf_m = 1'b1; sb_op.push_back(2'b11); end
      else begin sp_m--; sb_pc.push_back(stk[sp_m]); sb_op.push_back(2'b01); end
    end
    @(negedge clk);
    call_req = 1'b0; ret_req = 1'b0; clear_err = 1'b0;
    check_status(tag);
    for (int i = 0; i < 6 && busy; i++) @(negedge clk);
    if (busy) chk({tag, "_idle_timeout"}, 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sp_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  initial begin
    // Reset values
    apply_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_load_en", 32'(pc_load_en), 32'(0));
    chk("rst_load_val", 32'(pc_load_value), 32'(0));
    check_status("rst");

    // Round trip
    do_op(1'b1, 1'b0, 8'h12, 1'b0, "call_12");
    do_op(1'b1, 1'b0, 8'h34, 1'b0, "call_34");
    do_op(1'b0, 1'b1, 8'h00, 1'b0, "ret_1");
    do_op(1'b0, 1'b1, 8'h00, 1'b0, "ret_2");

    // Underflow and clear race
    do_op(1'b0, 1'b1, 8'h00, 1'b0, "unf");
    do_op(1'b0, 1'b0, 8'h00, 1'b1, "clr");
    do_op(1'b0, 1'b1, 8'h00, 1'b1, "unf_clr_race");
    do_op(1'b0, 1'b0, 8'h00, 1'b1, "clr2");

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 8'(i), 1'b0, "fill");
    do_op(1'b1, 1'b0, 8'hFF, 1'b0, "ovf");
    do_op(1'b0, 1'b1, 8'h00, 1'b0, "ret_after_ovf");
    do_op(1'b0, 1'b0, 8'h00, 1'b1, "clr_ovf");
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 8'h00, 1'b0, "drain");

    // Simultaneous call+ret, then a call held through ACK is ignored
    apply_reset();
    @(negedge clk);
    call_req = 1'b1; ret_req = 1'b1; pc_current = 8'hA5;
    stk[0] = 8'hA5; sp_m = 1; sb_op.push_back(2'b00);
    @(negedge clk);
    ret_req = 1'b0; pc_current = 8'h5A;
    check_status("both");
    @(negedge clk);
    call_req = 1'b0;
    check_status("busy_drop");
    @(negedge clk);
    check_status("busy_drop2");

    // Reset asserted during LOAD
    @(negedge clk);
    ret_req = 1'b1;
    @(posedge clk);
    ret_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    sp_m = 0;
    chk("midrst_load_en", 32'(pc_load_en), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    check_status("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_status("post_rst");
    do_op(1'b0, 1'b1, 8'h00, 1'b0, "post_rst_unf");

    repeat (2) @(negedge clk);
    chk("sb_pc_left", 32'(sb_pc.size()), 32'(0));
    chk("sb_op_left", 32'(sb_op.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
